// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ddr_pkg
//  Description : Shared types and constants for the two-player dance game:
//                round state encoding, arrow one-hot codes and score width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_SHOW   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Arrow button codes, bit0..3 = left/down/up/right
  localparam logic [3:0] ARROW_LEFT  = 4'b0001;
  localparam logic [3:0] ARROW_DOWN  = 4'b0010;
  localparam logic [3:0] ARROW_UP    = 4'b0100;
  localparam logic [3:0] ARROW_RIGHT = 4'b1000;

  // Hit counter width
  localparam int SCORE_W = 8;

  // The target arrow is selected by the two low bits of the generator state
  function automatic logic [3:0] arrow_of(input logic [7:0] lfsr_state);
    logic [3:0] code;
    case (lfsr_state[1:0])
      2'd0:    code = ARROW_LEFT;
      2'd1:    code = ARROW_DOWN;
      2'd2:    code = ARROW_UP;
      default: code = ARROW_RIGHT;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arrow_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : arrow_lfsr
//  Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifting left with
//                feedback into bit0. Reloads SEED on load, steps on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module arrow_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic       feedback;

  // Next generator value: reload has priority over a step
  always_comb begin
    feedback = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
    state_d  = state_q;
    if (load) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = {state_q[6:0], feedback};
    end
  end

  // Generator register, returns to the seed on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/step_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : step_round_controller
//  Description : Round sequencer for the two-player dance game. Paces the
//                lead-in beat and NUM_STEPS steps, shows a pseudo-random target
//                arrow in a timed window and judges each player once per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_round_controller
  import ddr_pkg::*;
#(
  parameter int         BEAT_CYCLES   = 25_000_000,
  parameter int         WINDOW_CYCLES = 10_000_000,
  parameter int         NUM_STEPS     = 32,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         a_keys,
  input  logic [3:0]         b_keys,
  output logic [3:0]         arrow,
  output logic               window_open,
  output logic               a_hit,
  output logic               b_hit,
  output logic               a_miss,
  output logic               b_miss,
  output logic [SCORE_W-1:0] a_score,
  output logic [SCORE_W-1:0] b_score,
  output logic [5:0]         step_idx,
  output logic               busy,
  output logic               done
);

  localparam int             CNT_W     = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BEAT_CYCLES - WINDOW_CYCLES - 1);
  localparam logic [5:0]     STEP_LAST = 6'(NUM_STEPS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       step_q, step_d;
  logic             round_start;
  logic             step_advance;
  logic             last_show;
  logic             in_show;
  logic [7:0]       lfsr_state;
  logic [3:0]       target;

  // Next state, beat counter and step index; flags round start / step change
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    step_d       = step_q;
    round_start  = 1'b0;
    step_advance = 1'b0;
    last_show    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        cnt_d = cnt_q;
        if (start) begin
          state_d     = ST_LEAD;
          cnt_d       = '0;
          step_d      = '0;
          round_start = 1'b1;
        end
      end
      ST_LEAD: begin
        if (cnt_q == BEAT_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == WIN_LAST) begin
          last_show = 1'b1;
          state_d   = ST_GAP;
          cnt_d     = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (step_q == STEP_LAST) begin
            state_d = ST_FINISH;
          end else begin
            state_d      = ST_SHOW;
            step_d       = step_q + 6'd1;
            step_advance = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  arrow_lfsr #(
    .SEED(LFSR_SEED)
  ) u_arrow_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (round_start),
    .advance(step_advance),
    .state  (lfsr_state)
  );

  assign target  = arrow_of(lfsr_state);
  assign in_show = (state_q == ST_SHOW);

  logic [1:0][3:0]         keys_in;
  logic [1:0]              hit_w;
  logic [1:0]              miss_w;
  logic [1:0][SCORE_W-1:0] score_w;

  assign keys_in = {b_keys, a_keys};

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [3:0]         keys_q, keys_d;
    logic [3:0]         rise;
    logic               judged_q, judged_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;

    // One verdict per step: first rising edge in the window, or no-press at close
    always_comb begin
      keys_d   = keys_in[p];
      rise     = keys_in[p] & ~keys_q;
      judged_d = judged_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      score_d  = score_q;
      if (round_start || step_advance) begin
        judged_d = 1'b0;
        if (round_start) begin
          score_d = '0;
        end
      end else if (in_show && !judged_q) begin
        if (rise != 4'd0) begin
          judged_d = 1'b1;
          if (rise == target) begin
            hit_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            miss_d = 1'b1;
          end
        end else if (last_show) begin
          judged_d = 1'b1;
          miss_d   = 1'b1;
        end
      end
    end

    // Per-player key history, verdict pulses and hit counter
    always_ff @(posedge clock) begin
      if (reset) begin
        keys_q   <= '0;
        judged_q <= 1'b0;
        hit_q    <= 1'b0;
        miss_q   <= 1'b0;
        score_q  <= '0;
      end else begin
        keys_q   <= keys_d;
        judged_q <= judged_d;
        hit_q    <= hit_d;
        miss_q   <= miss_d;
        score_q  <= score_d;
      end
    end

    assign hit_w[p]   = hit_q;
    assign miss_w[p]  = miss_q;
    assign score_w[p] = score_q;
  end

  assign arrow       = in_show ? target : 4'd0;
  assign window_open = in_show;
  assign a_hit       = hit_w[0];
  assign b_hit       = hit_w[1];
  assign a_miss      = miss_w[0];
  assign b_miss      = miss_w[1];
  assign a_score     = score_w[0];
  assign b_score     = score_w[1];
  assign step_idx    = step_q;
  assign busy        = (state_q == ST_LEAD) || (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign done        = (state_q == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_step_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_round_controller
//  Description : Randomized bench for step_round_controller. A driver issues
//                rounds and predicts verdict pulses into per-player queues; a
//                monitor pops and compares whenever the DUT pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_round_controller;

  localparam int         B     = 8;
  localparam int         W     = 4;
  localparam int         S     = 3;
  localparam logic [7:0] SEED  = 8'h01;
  localparam int         TOTAL = B * (S + 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_keys = 4'd0;
  logic [3:0] b_keys = 4'd0;
  logic [3:0] arrow;
  logic       window_open, a_hit, b_hit, a_miss, b_miss, busy, done;
  logic [7:0] a_score, b_score;
  logic [5:0] step_idx;

  step_round_controller #(
    .BEAT_CYCLES  (B),
    .WINDOW_CYCLES(W),
    .NUM_STEPS    (S),
    .LFSR_SEED    (SEED)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a_keys     (a_keys),
    .b_keys     (b_keys),
    .arrow      (arrow),
    .window_open(window_open),
    .a_hit      (a_hit),
    .b_hit      (b_hit),
    .a_miss     (a_miss),
    .b_miss     (b_miss),
    .a_score    (a_score),
    .b_score    (b_score),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    bit hit;
    int score;
  } ev_t;

  ev_t        qa[$];
  ev_t        qb[$];
  logic [3:0] prev[2];
  bit         judged[2];
  int         sc[2];
  int         pt[2];
  logic [3:0] arrows[S];

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic int q_size(input int p);
    return (p == 0) ? qa.size() : qb.size();
  endfunction

  function automatic ev_t q_front(input int p);
    return (p == 0) ? qa[0] : qb[0];
  endfunction

  task automatic q_pop(input int p);
    if (p == 0) void'(qa.pop_front());
    else        void'(qb.pop_front());
  endtask

  task automatic q_push(input int p, input int c, input bit h, input int s);
    ev_t e;
    e.cyc = c; e.hit = h; e.score = s;
    if (p == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Key levels per stimulus mode
  function automatic logic [3:0] gen(input int mode, input bit show, input int t,
                                     input int ptv, input logic [3:0] arr,
                                     input logic [3:0] cur);
    case (mode)
      1:       return (show && t >= ptv) ? arr : 4'h0;
      2:       return (show && t == 0) ? rot(arr) : ((show && t == 2) ? arr : 4'h0);
      3:       return 4'hF;
      4:       return ($urandom_range(2, 0) == 0) ? 4'($urandom_range(15, 0)) : cur;
      5:       return (show && t >= ptv) ? (arr | rot(arr)) : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  // Judge one player's key level for bench cycle T
  task automatic judge(input int p, input logic [3:0] kv, input bit show, input int t,
                       input logic [3:0] arr, input int T);
    logic [3:0] rise;
    rise = kv & ~prev[p];
    if (show && !judged[p]) begin
      if (rise != 4'd0) begin
        judged[p] = 1'b1;
        if (rise == arr) begin
          if (sc[p] < 255) sc[p]++;
          q_push(p, T + 1, 1'b1, sc[p]);
        end else begin
          q_push(p, T + 1, 1'b0, sc[p]);
        end
      end else if (t == W - 1) begin
        judged[p] = 1'b1;
        q_push(p, T + 1, 1'b0, sc[p]);
      end
    end
    prev[p] = kv;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int p, input logic h, input logic m, input logic [7:0] s);
    ev_t e;
    while (q_size(p) > 0 && q_front(p).cyc < cyc) begin
      chk($sformatf("p%0d_pulse_missing", p), 0, 1);
      q_pop(p);
    end
    if (h || m) begin
      if (q_size(p) == 0 || q_front(p).cyc != cyc) begin
        chk($sformatf("p%0d_unexpected_pulse", p), int'({h, m}), 0);
      end else begin
        e = q_front(p);
        q_pop(p);
        chk($sformatf("p%0d_verdict", p), int'({h, m}), e.hit ? 2 : 1);
        chk($sformatf("p%0d_score", p), int'(s), e.score);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, a_hit, a_miss, a_score);
    mon(1, b_hit, b_miss, b_score);
  end

  // ---------------- driver ----------------
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arrow"}, int'(arrow), 0);
    chk({tag, "_window"}, int'(window_open), 0);
    chk({tag, "_pulses"}, int'({a_hit, a_miss, b_hit, b_miss}), 0);
    chk({tag, "_scores"}, int'({a_score, b_score}), 0);
    chk({tag, "_step"}, int'(step_idx), 0);
    chk({tag, "_busy_done"}, int'({busy, done}), 0);
  endtask

  task automatic run_round(input int ma, input int mb, input int fpt, input bit mid,
                           input int rst_at);
    int         mid_r, T, k, t, step;
    bit         show;
    logic [3:0] arr;
    mid_r = mid ? $urandom_range(TOTAL - 3, 2) : -1;
    @(negedge clock);
    start = 1'b1;
    for (int r = 0; r <= TOTAL + 1; r++) begin
      @(negedge clock);
      T     = cyc;
      start = (r == mid_r);
      show  = 1'b0;
      t     = 0;
      k     = 0;
      if (r >= B) begin
        k = (r - B) / B;
        t = (r - B) % B;
        if (k >= S) k = S - 1;
        else        show = (t < W);
      end
      step = k;
      arr  = show ? arrows[k] : 4'd0;
      if (r == 0) begin
        sc[0] = 0; sc[1] = 0; judged[0] = 1'b0; judged[1] = 1'b0;
      end
      chk("window_open", int'(window_open), int'(show));
      chk("arrow", int'(arrow), int'(arr));
      chk("busy", int'(busy), int'(r < TOTAL));
      chk("done", int'(done), int'(r >= TOTAL));
      chk("step_idx", int'(step_idx), step);
      if (r == rst_at) begin
        reset  = 1'b1;
        a_keys = 4'd0; b_keys = 4'd0;
        prev[0] = 4'd0; prev[1] = 4'd0;
        @(negedge clock);
        check_idle_outputs("after_reset");
        reset = 1'b0;
        return;
      end
      if (show && t == 0) begin
        for (int p = 0; p < 2; p++) begin
          judged[p] = 1'b0;
          pt[p] = (fpt >= 0) ? fpt : $urandom_range(W - 1, 0);
        end
      end
      a_keys = gen(ma, show, t, pt[0], arrows[k], a_keys);
      b_keys = gen(mb, show, t, pt[1], arrows[k], b_keys);
      judge(0, a_keys, show, t, arrows[k], T);
      judge(1, b_keys, show, t, arrows[k], T);
    end
    chk("final_a_score", int'(a_score), sc[0]);
    chk("final_b_score", int'(b_score), sc[1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    s = SEED;
    for (int k = 0; k < S; k++) begin
      arrows[k] = 4'b0001 << s[1:0];
      s = lfsr_next(s);
    end
    prev[0] = 4'd0; prev[1] = 4'd0;
    judged[0] = 1'b0; judged[1] = 1'b0;
    sc[0] = 0; sc[1] = 0;
    pt[0] = 0; pt[1] = 0;

    repeat (3) @(negedge clock);
    check_idle_outputs("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_idle_outputs("idle");
    end

    run_round(1, 0, 1, 1'b0, -1);          // A hits every step, B never presses
    run_round(2, 2, -1, 1'b0, -1);         // wrong then correct press
    run_round(1, 1, 3, 1'b0, -1);          // simultaneous presses in last window cycle
    run_round(3, 5, -1, 1'b1, -1);         // held buttons / extra button, start mid-round
    run_round(1, 1, -1, 1'b0, B + B + 1);  // reset during the second window
    run_round(1, 4, -1, 1'b0, -1);         // replay after reset
    for (int i = 0; i < 8; i++) begin
      run_round($urandom_range(5, 0), $urandom_range(5, 0), -1, 1'($urandom_range(1, 0)), -1);
    end

    repeat (3) @(negedge clock);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_round_controller.md
# step_round_controller

Round sequencer for the two-player dance game. It consumes the debounced, level-valued arrow buttons for players A and B and generates a pseudo-random one-hot target arrow once per beat. It opens a timed hit window for each target and judges each player once per step, counting hits and misses. It sits between the input debounce stage and the score/display logic, and owns round start, step pacing and end-of-round.

## Interface
Parameters:
- BEAT_CYCLES, 25_000_000, clock cycles per step (0.5 s at 50 MHz); must be ≥ WINDOW_CYCLES + 1.
- WINDOW_CYCLES, 10_000_000, cycles the hit window is open at the start of each step; must be ≥ 2.
- NUM_STEPS, 32, steps per round; range 1..63.
- LFSR_SEED, 8'hA5, arrow generator seed; must be nonzero.

Ports (reset is synchronous, active-high; the clock is `clock`):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE or FINISH to begin a round.
- a_keys  in  4  player A debounced button levels, bit0..3 = left/down/up/right.
- b_keys  in  4  player B debounced button levels, same mapping.
- arrow  out  4  current target, one-hot while window_open, else 0.
- window_open  out  1  hit window active.
- a_hit, b_hit  out  1  one-cycle pulse: correct press judged.
- a_miss, b_miss  out  1  one-cycle pulse: wrong press or no press.
- a_score, b_score  out  8  hit counts, saturating at 255.
- step_idx  out  6  index of the current step, 0..NUM_STEPS-1.
- busy  out  1  round in progress (LEAD/SHOW/GAP).
- done  out  1  high in FINISH.

## Operation
- States: IDLE, LEAD, SHOW, GAP, FINISH.
- IDLE → LEAD on start=1. On entry to LEAD:
  - beat counter = 0, scores = 0, step_idx = 0, LFSR = LFSR_SEED, per-player judged flags cleared.
- LEAD: lasts BEAT_CYCLES cycles (lead-in beat); arrow = 0; then → SHOW.
- SHOW: lasts WINDOW_CYCLES cycles.
  - window_open = 1; arrow = one-hot(lfsr[1:0]).
  - After SHOW → GAP.
- GAP: lasts BEAT_CYCLES − WINDOW_CYCLES cycles; arrow = 0.
  - At the end of GAP: if step_idx == NUM_STEPS−1 → FINISH; else step_idx += 1, LFSR advances one step, judged flags cleared, → SHOW.
- FINISH: done = 1; scores held. start=1 → LEAD (new round, scores cleared). start is ignored while busy.
- Arrow LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit0. Advances only at step boundaries.
- Press detection: rise = keys & ~keys_q, where keys_q is the previous-cycle register of keys. keys_q keeps updating in all states, so a button already held before SHOW is not a press.
- Judging, independent per player, at most one verdict per player per step:
  - During SHOW, with the player not yet judged and rise ≠ 0:
    - rise == arrow → hit, score += 1 (saturating at 255).
    - any other nonzero rise, including the correct arrow plus an extra button → miss.
    - Either verdict sets the judged flag.
  - On the last SHOW cycle, a player not yet judged and with rise == 0 → miss.
  - A press in the last SHOW cycle is judged as a press, not as no-press.
  - Rises outside SHOW are ignored.
- Both players may be judged in the same cycle; the pulses are independent.
- Reset mid-round: everything returns to the reset values in the next cycle; an in-flight pulse is dropped.

## Timing
- Reset values:
  - state = IDLE; arrow = 0; window_open = 0; all pulses = 0.
  - scores = 0; step_idx = 0; busy = 0; done = 0; LFSR = LFSR_SEED; keys_q = 0.
- Latencies:
  - start sampled at edge N → busy = 1 from edge N.
  - First window_open = 1 at cycle N + BEAT_CYCLES.
  - Press visible on keys in cycle T within SHOW → hit/miss pulse and score update registered at edge T+1.
  - No-press miss pulse follows the last SHOW cycle by one cycle, concurrent with the first GAP cycle.
- Total round length from start: BEAT_CYCLES × (NUM_STEPS + 1) cycles, then done.
- All outputs registered; no combinational path from keys to any output.

## Structure
- Shared package ddr_pkg:
  - state enum.
  - Arrow bit constants (ARROW_LEFT = 4'b0001 … ARROW_RIGHT = 4'b1000).
  - Score width constant (8).
- One sub-module, arrow_lfsr: inputs load and advance, parameter SEED; output 8-bit state.
- Per-player judging is duplicated inline (a generate loop or two identical always blocks). It is not a separate module.

## Test plan
All scenarios use BEAT_CYCLES=8, WINDOW_CYCLES=4, NUM_STEPS=3, LFSR_SEED=8'h01.
- Reset then idle 20 cycles → all outputs 0, busy=0, done=0.
- start pulse; player A presses the correct arrow in SHOW cycle 2, every step → three a_hit pulses, a_score=3. Player B idle → three b_miss pulses, b_score=0. done=1 at cycle 32 after start.
- Player A presses a wrong arrow, then the correct one, in the same window → single a_miss, no a_hit, a_score unchanged.
- Both players press the correct arrow in the same cycle → a_hit and b_hit asserted in the same cycle, both scores increment.
- Button held from LEAD through SHOW → no hit; miss at window close. start asserted mid-round → ignored.
- Reset asserted during the second SHOW → next cycle state IDLE, scores 0, arrow 0, no pulses. A following start replays the identical arrow sequence.
